// File: rtl/fetch_stage_if.sv
// Pipelined instruction-memory request/response port between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: fetch PC, credit-limited imem requests,
// in-order fetch queue and the IF/ID pipeline register.

module fetch_stage_chk #(
  parameter int CW     = 3,
  parameter int QDEPTH = 2
) (
  input logic          i_clk,
  input logic          i_reset,
  input logic          push_i,
  input logic          pop_i,
  input logic          clear_i,
  input logic [CW-1:0] qcount_i
);
  // a push into a full queue that is neither popped nor cleared loses an instruction
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(push_i && !pop_i && !clear_i && (qcount_i == CW'(QDEPTH))));
endmodule

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          stall_pc,
  input  logic          stall_IF,
  input  logic          flush_IF,
  input  logic          flush_ID,
  input  logic          pc_sel_EX,
  input  logic [31:0]   target_EX,
  fetch_stage_if.master imem,
  output logic [31:0]   pc_ID,
  output logic [31:0]   inst_ID,
  output logic          valid_ID
);
  localparam int            CW      = 3;
  localparam int            PW      = (QDEPTH > 2) ? 2 : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(QDEPTH - 1);

  logic [31:0]   pc_fetch_q, pc_fetch_d, pc_resp_q, pc_resp_d;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] qcount_q, qcount_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_idx_s;
  logic [31:0]   q_pc_q   [QDEPTH];
  logic [31:0]   q_inst_q [QDEPTH];
  logic          req_s, hs_s, drop_s, push_s, pop_s, clear_s;
  logic [31:0]   target_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign target_s = target_EX & 32'hFFFF_FFFC;

  // Two credit limits: stale responses still owed, and room left in the queue.
  assign req_s = !i_reset && !stall_pc && !pc_sel_EX &&
                 ((outstanding_q + drop_cnt_q) < DEPTH_C) &&
                 ((outstanding_q + qcount_q) < DEPTH_C);

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc_fetch_q;

  assign hs_s    = req_s && imem.imem_gnt;
  assign drop_s  = imem.imem_rvalid && (drop_cnt_q != {CW{1'b0}});
  assign push_s  = imem.imem_rvalid && (drop_cnt_q == {CW{1'b0}}) && !pc_sel_EX;
  assign pop_s   = !flush_ID && !pc_sel_EX && !stall_IF && (qcount_q != {CW{1'b0}});
  assign clear_s = pc_sel_EX || flush_IF;

  // PC and credit counters; a redirect turns every in-flight request stale
  always_comb begin
    pc_fetch_d    = pc_fetch_q;
    pc_resp_d     = pc_resp_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (pc_sel_EX) begin
      pc_fetch_d    = target_s;
      pc_resp_d     = target_s;
      outstanding_d = {CW{1'b0}};
      drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(imem.imem_rvalid);
    end else begin
      if (hs_s) pc_fetch_d = pc_fetch_q + 32'd4;
      else      pc_fetch_d = pc_fetch_q;
      if (push_s) pc_resp_d = pc_resp_q + 32'd4;
      else        pc_resp_d = pc_resp_q;
      if (drop_s) drop_cnt_d = drop_cnt_q - CW'(1);
      else        drop_cnt_d = drop_cnt_q;
      outstanding_d = outstanding_q + CW'(hs_s) - CW'(push_s);
    end
  end

  // queue pointers; a clear still keeps a same-cycle push
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    qcount_d = qcount_q;
    wr_idx_s = wr_ptr_q;
    if (clear_s) begin
      rd_ptr_d = {PW{1'b0}};
      wr_idx_s = {PW{1'b0}};
      wr_ptr_d = push_s ? PW'(1) : {PW{1'b0}};
      qcount_d = CW'(push_s);
    end else begin
      if (pop_s) rd_ptr_d = ptr_inc(rd_ptr_q);
      else       rd_ptr_d = rd_ptr_q;
      if (push_s) wr_ptr_d = ptr_inc(wr_ptr_q);
      else        wr_ptr_d = wr_ptr_q;
      qcount_d = qcount_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // state registers, queue storage and IF/ID
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_fetch_q    <= RESET_PC;
      pc_resp_q     <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
      qcount_q      <= {CW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]   <= 32'h0000_0000;
        q_inst_q[i] <= NOP_INST;
      end
      pc_ID    <= 32'h0000_0000;
      inst_ID  <= NOP_INST;
      valid_ID <= 1'b0;
    end else begin
      pc_fetch_q    <= pc_fetch_d;
      pc_resp_q     <= pc_resp_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      qcount_q      <= qcount_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push_s) begin
        q_pc_q[wr_idx_s]   <= pc_resp_q;
        q_inst_q[wr_idx_s] <= imem.imem_rdata;
      end
      if (flush_ID || pc_sel_EX) begin
        valid_ID <= 1'b0;
        inst_ID  <= NOP_INST;
      end else if (stall_IF) begin
        valid_ID <= valid_ID;
      end else if (qcount_q != {CW{1'b0}}) begin
        pc_ID    <= q_pc_q[rd_ptr_q];
        inst_ID  <= q_inst_q[rd_ptr_q];
        valid_ID <= 1'b1;
      end else begin
        valid_ID <= 1'b0;
        inst_ID  <= NOP_INST;
      end
    end
  end

  fetch_stage_chk #(.CW(CW), .QDEPTH(QDEPTH)) u_chk (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .clear_i  (clear_s),
    .qcount_i (qcount_q)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model with in-order responses and a
// scoreboard of granted addresses that IF/ID must present in order.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk, i_reset;
  logic        stall_pc, stall_IF, flush_IF, flush_ID, pc_sel_EX;
  logic [31:0] target_EX, pc_ID, inst_ID;
  logic        valid_ID;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pend[$];
  logic [31:0] sb[$];
  logic [31:0] seen[$];
  bit          mem_en;
  bit          last_hs;
  logic [31:0] prev_pc, prev_inst, hold_addr;
  logic        prev_valid;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2), .NOP_INST(NOP)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .stall_pc  (stall_pc),
    .stall_IF  (stall_IF),
    .flush_IF  (flush_IF),
    .flush_ID  (flush_ID),
    .pc_sel_EX (pc_sel_EX),
    .target_EX (target_EX),
    .imem      (bus.master),
    .pc_ID     (pc_ID),
    .inst_ID   (inst_ID),
    .valid_ID  (valid_ID)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0003;
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    if (i < seen.size()) return seen[i];
    else return 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    prev_pc    = pc_ID;
    prev_inst  = inst_ID;
    prev_valid = valid_ID;
  endtask

  task automatic check_id(input bit hold, input bit kill);
    logic [31:0] e;
    if (kill) begin
      chk("kill_valid", 32'(valid_ID), 32'd0);
      chk("kill_inst", inst_ID, NOP);
      chk("kill_pc", pc_ID, prev_pc);
    end else if (hold) begin
      chk("hold_valid", 32'(valid_ID), 32'(prev_valid));
      chk("hold_pc", pc_ID, prev_pc);
      chk("hold_inst", inst_ID, prev_inst);
    end else if (valid_ID) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("id_pc", pc_ID, e);
        chk("id_inst", inst_ID, mem_word(e));
        seen.push_back(pc_ID);
      end
    end else begin
      chk("idle_inst", inst_ID, NOP);
    end
    snap();
  endtask

  // one clock: drive memory, sample handshakes before the edge, check after it
  task automatic tick();
    logic rv, hs, kill, hold, redir;
    logic [31:0] ha;
    if (mem_en && pend.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0000_0000;
    end
    @(negedge i_clk);
    rv    = bus.imem_rvalid;
    hs    = bus.imem_req & bus.imem_gnt;
    ha    = bus.imem_addr;
    redir = pc_sel_EX;
    kill  = flush_ID | pc_sel_EX;
    hold  = stall_IF;
    @(posedge i_clk);
    #1;
    if (rv) void'(pend.pop_front());
    if (redir) sb.delete();
    if (hs) begin
      pend.push_back(ha);
      sb.push_back(ha);
    end
    last_hs = hs;
    check_id(hold, kill);
  endtask

  task automatic collect(input int n, input int bound);
    seen.delete();
    for (int i = 0; i < bound && seen.size() < n; i++) tick();
    chk("collect_count", 32'(seen.size()), 32'(n));
  endtask

  initial begin
    i_reset = 1'b1; stall_pc = 1'b0; stall_IF = 1'b0; flush_IF = 1'b0;
    flush_ID = 1'b0; pc_sel_EX = 1'b0; target_EX = 32'h0000_0000;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0000_0000;
    mem_en = 1'b1; last_hs = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);
    chk("rst_pc", pc_ID, 32'h0000_0000);
    chk("rst_inst", inst_ID, NOP);
    chk("rst_valid", 32'(valid_ID), 32'd0);
    i_reset = 1'b0;
    snap();

    tick(); chk("lat_c1", 32'(valid_ID), 32'd0);
    tick(); chk("lat_c2", 32'(valid_ID), 32'd0);
    tick(); chk("lat_c3", 32'(valid_ID), 32'd1);
    chk("lat_pc", pc_ID, 32'h0000_0000);
    seen.delete();
    repeat (16) tick();
    chk("freerun_progress", 32'(seen.size() >= 6), 32'd1);

    stall_pc = 1'b1; stall_IF = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_req", 32'(bus.imem_req), 32'd0);
    end
    stall_pc = 1'b0; stall_IF = 1'b0;
    collect(4, 20);

    // starve responses so two requests are in flight, then redirect
    mem_en = 1'b0;
    repeat (4) tick();
    chk("credit_block_req", 32'(bus.imem_req), 32'd0);
    pc_sel_EX = 1'b1; target_EX = 32'h0000_0100;
    tick();
    pc_sel_EX = 1'b0; mem_en = 1'b1;
    collect(2, 20);
    chk("redir_pc0", seen_at(0), 32'h0000_0100);
    chk("redir_pc1", seen_at(1), 32'h0000_0104);

    stall_IF = 1'b1; flush_ID = 1'b1;
    tick();
    stall_IF = 1'b0; flush_ID = 1'b0;
    pc_sel_EX = 1'b1; target_EX = 32'h0000_0203;
    tick();
    pc_sel_EX = 1'b0;
    chk("align_addr", bus.imem_addr, 32'h0000_0200);
    collect(2, 20);
    chk("align_pc0", seen_at(0), 32'h0000_0200);
    chk("align_pc1", seen_at(1), 32'h0000_0204);

    bus.imem_gnt = 1'b0;
    repeat (3) tick();
    hold_addr = bus.imem_addr;
    repeat (4) begin
      tick();
      chk("nogrant_req", 32'(bus.imem_req), 32'd1);
      chk("nogrant_addr", bus.imem_addr, hold_addr);
    end
    bus.imem_gnt = 1'b1;
    collect(2, 20);

    // fill the queue behind a stalled IF/ID, then reset mid-cycle
    stall_IF = 1'b1;
    repeat (6) tick();
    chk("full_valid_held", 32'(valid_ID), 32'd1);
    #3;
    i_reset = 1'b1;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0000_0000);
    chk("arst_pc", pc_ID, 32'h0000_0000);
    chk("arst_inst", inst_ID, NOP);
    chk("arst_valid", 32'(valid_ID), 32'd0);
    pend.delete(); sb.delete();
    bus.imem_rvalid = 1'b0; stall_IF = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    snap();
    collect(2, 20);
    chk("restart_pc0", seen_at(0), 32'h0000_0000);
    chk("restart_pc1", seen_at(1), 32'h0000_0004);

    pc_sel_EX = 1'b1; target_EX = 32'hFFFF_FFFC;
    tick();
    pc_sel_EX = 1'b0;
    chk("wrap_first_addr", bus.imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_hs) break;
    end
    chk("wrap_hs", 32'(last_hs), 32'd1);
    chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);
    collect(2, 20);
    chk("wrap_pc0", seen_at(0), 32'hFFFF_FFFC);
    chk("wrap_pc1", seen_at(1), 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
